// File: rtl/reward_pkg.sv
// Shared codes for the reward scheduler: game status, reward types, FSM states, grid cell.
package reward_pkg;

    localparam logic [1:0] RUNNING = 2'b10;

    typedef enum logic [1:0] {
        RW_NONE    = 2'd0,
        RW_PROTECT = 2'd1,
        RW_SLOW    = 2'd2,
        RW_GRADE   = 2'd3
    } reward_type_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPAWN = 3'd1,
        ST_REQUEST    = 3'd2,
        ST_VALIDATE   = 3'd3,
        ST_PLACED     = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
    } cell_t;

endpackage

// File: rtl/reward_effect_timer.sv
// Per-type effect countdown: load has priority over tick; active follows remain one clk after load.
// No backpressure; clr (game not running) overrides everything.
module reward_effect_timer #(
    parameter int CNT_W        = 10,
    parameter int EFFECT_TICKS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             tick,
    output logic             active,
    output logic [CNT_W-1:0] remain
);

    logic [CNT_W-1:0] remain_nxt;

    always_comb begin
        remain_nxt = remain;
        if (clr)
            remain_nxt = '0;
        else if (load)
            remain_nxt = CNT_W'(EFFECT_TICKS);
        else if (tick && remain != '0)
            remain_nxt = remain - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
            active <= 1'b0;
        end else begin
            remain <= remain_nxt;
            active <= (remain_nxt != '0);
        end
    end

endmodule

// File: rtl/reward_scheduler.sv
// Reward spawn/validate/lifetime sequencer with protect and slow effect timers and a grade pulse.
// gen_req is held until gen_ack; effects rise 1 clk after the collecting tick.
module reward_scheduler
    import reward_pkg::*;
#(
    parameter int SPAWN_DELAY  = 20,
    parameter int LIFETIME     = 40,
    parameter int EFFECT_TICKS = 30,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_4hz,
    input  logic [1:0]       game_status,
    input  logic [5:0]       head_x,
    input  logic [5:0]       head_y,
    input  logic [5:0]       food_x,
    input  logic [5:0]       food_y,
    output logic             gen_req,
    input  logic             gen_ack,
    input  logic [1:0]       gen_type,
    input  logic [5:0]       gen_x,
    input  logic [5:0]       gen_y,
    output logic             reward_valid,
    output logic [5:0]       reward_x,
    output logic [5:0]       reward_y,
    output logic [1:0]       reward_type,
    output logic             reward_protected,
    output logic             reward_slowly,
    output logic             grade_pulse,
    output logic [CNT_W-1:0] protect_remain,
    output logic [CNT_W-1:0] slow_remain
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state;
    logic [CNT_W-1:0]   delay_cnt;
    logic [CNT_W-1:0]   life_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_nxt;
    cell_t              cand;
    logic [1:0]         cand_type;

    logic running;
    logic head_hit;
    logic cand_bad;
    logic protect_load;
    logic slow_load;

    assign running   = (game_status == RUNNING);
    assign retry_nxt = retry_cnt + 1'b1;
    assign cand_bad  = (cand_type == RW_NONE) || (cand == {food_x, food_y}) || (cand == {head_x, head_y});

    // Collision is decided in the tick cycle so the effect timer loads on the same edge.
    assign head_hit     = tick_4hz && (state == ST_PLACED) && ({head_x, head_y} == {reward_x, reward_y});
    assign protect_load = head_hit && (reward_type == RW_PROTECT);
    assign slow_load    = head_hit && (reward_type == RW_SLOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            delay_cnt    <= '0;
            life_cnt     <= '0;
            retry_cnt    <= '0;
            cand         <= '0;
            cand_type    <= '0;
            gen_req      <= 1'b0;
            reward_valid <= 1'b0;
            reward_x     <= '0;
            reward_y     <= '0;
            reward_type  <= '0;
            grade_pulse  <= 1'b0;
        end else if (!running) begin
            state        <= ST_IDLE;
            delay_cnt    <= '0;
            life_cnt     <= '0;
            retry_cnt    <= '0;
            gen_req      <= 1'b0;
            reward_valid <= 1'b0;
            grade_pulse  <= 1'b0;
        end else begin
            grade_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    delay_cnt <= CNT_W'(SPAWN_DELAY);
                    state     <= ST_WAIT_SPAWN;
                end
                ST_WAIT_SPAWN: begin
                    if (tick_4hz) begin
                        if (delay_cnt <= CNT_W'(1)) begin
                            delay_cnt <= '0;
                            retry_cnt <= '0;
                            gen_req   <= 1'b1;
                            state     <= ST_REQUEST;
                        end else begin
                            delay_cnt <= delay_cnt - 1'b1;
                        end
                    end
                end
                ST_REQUEST: begin
                    if (gen_ack) begin
                        cand      <= {gen_x, gen_y};
                        cand_type <= gen_type;
                        gen_req   <= 1'b0;
                        state     <= ST_VALIDATE;
                    end
                end
                ST_VALIDATE: begin
                    if (cand_bad) begin
                        retry_cnt <= retry_nxt;
                        if (retry_nxt == RETRY_W'(MAX_RETRY)) begin
                            delay_cnt <= CNT_W'(SPAWN_DELAY);
                            state     <= ST_WAIT_SPAWN;
                        end else begin
                            gen_req <= 1'b1;
                            state   <= ST_REQUEST;
                        end
                    end else begin
                        reward_valid <= 1'b1;
                        reward_x     <= cand.x;
                        reward_y     <= cand.y;
                        reward_type  <= cand_type;
                        life_cnt     <= CNT_W'(LIFETIME);
                        state        <= ST_PLACED;
                    end
                end
                ST_PLACED: begin
                    if (head_hit) begin
                        reward_valid <= 1'b0;
                        grade_pulse  <= (reward_type == RW_GRADE);
                        delay_cnt    <= CNT_W'(SPAWN_DELAY);
                        state        <= ST_WAIT_SPAWN;
                    end else if (tick_4hz) begin
                        if (life_cnt <= CNT_W'(1)) begin
                            life_cnt     <= '0;
                            reward_valid <= 1'b0;
                            delay_cnt    <= CNT_W'(SPAWN_DELAY);
                            state        <= ST_WAIT_SPAWN;
                        end else begin
                            life_cnt <= life_cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    reward_effect_timer #(.CNT_W(CNT_W), .EFFECT_TICKS(EFFECT_TICKS)) u_protect_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!running),
        .load   (protect_load),
        .tick   (tick_4hz),
        .active (reward_protected),
        .remain (protect_remain)
    );

    reward_effect_timer #(.CNT_W(CNT_W), .EFFECT_TICKS(EFFECT_TICKS)) u_slow_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!running),
        .load   (slow_load),
        .tick   (tick_4hz),
        .active (reward_slowly),
        .remain (slow_remain)
    );

endmodule

// File: tb/tb_reward_scheduler.sv
// Self-checking bench for reward_scheduler: event timings go through a scoreboard queue, snapshots through check_val.
module tb_reward_scheduler;
    import reward_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_4hz = 1'b0;
    logic [1:0] game_status = 2'b00;
    logic [5:0] head_x = '0, head_y = '0;
    logic [5:0] food_x = 6'd1, food_y = 6'd1;
    logic       gen_ack = 1'b0;
    logic [1:0] gen_type = '0;
    logic [5:0] gen_x = '0, gen_y = '0;

    logic       gen_req, reward_valid, reward_protected, reward_slowly, grade_pulse;
    logic [5:0] reward_x, reward_y;
    logic [1:0] reward_type;
    logic [9:0] protect_remain, slow_remain;

    reward_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .tick_4hz         (tick_4hz),
        .game_status      (game_status),
        .head_x           (head_x),
        .head_y           (head_y),
        .food_x           (food_x),
        .food_y           (food_y),
        .gen_req          (gen_req),
        .gen_ack          (gen_ack),
        .gen_type         (gen_type),
        .gen_x            (gen_x),
        .gen_y            (gen_y),
        .reward_valid     (reward_valid),
        .reward_x         (reward_x),
        .reward_y         (reward_y),
        .reward_type      (reward_type),
        .reward_protected (reward_protected),
        .reward_slowly    (reward_slowly),
        .grade_pulse      (grade_pulse),
        .protect_remain   (protect_remain),
        .slow_remain      (slow_remain)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb_q[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", obs, -1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick_4hz = 1'b1;
        @(negedge clk);
        tick_4hz = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse_tick();
    endtask

    task automatic hit_tick(input logic [5:0] x, input logic [5:0] y);
        head_x = x; head_y = y;
        tick_4hz = 1'b1;
        @(negedge clk);
        tick_4hz = 1'b0;
        head_x = '0; head_y = '0;
        @(negedge clk);
    endtask

    task automatic give_ack(input logic [1:0] t, input logic [5:0] x, input logic [5:0] y);
        gen_ack = 1'b1; gen_type = t; gen_x = x; gen_y = y;
        @(negedge clk);
        gen_ack = 1'b0; gen_type = '0;
        @(negedge clk);
    endtask

    // Ticks applied until gen_req is seen, bounded.
    task automatic measure_req(input string tag);
        int n;
        n = 0;
        sb_push(tag, 20);
        while (!gen_req && n < 60) begin
            pulse_tick();
            n++;
        end
        sb_pop(n);
    endtask

    task automatic spawn(input string tag, input logic [1:0] t, input logic [5:0] x, input logic [5:0] y);
        measure_req(tag);
        give_ack(t, x, y);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        step(); step();
        check_val("rst_flags", int'({gen_req, reward_valid, reward_protected, reward_slowly, grade_pulse}), 0);
        check_val("rst_cell", int'({reward_x, reward_y, reward_type}), 0);
        check_val("rst_remain", int'({protect_remain, slow_remain}), 0);

        rst = 1'b0;
        game_status = RUNNING;
        step();
        spawn("first_req", RW_PROTECT, 6'd3, 6'd4);
        check_val("place_valid", int'(reward_valid), 1);
        check_val("place_type", int'(reward_type), 1);

        // Asynchronous reset while a reward is placed
        ticks(3);
        #2 rst = 1'b1;
        #1;
        check_val("arst_flags", int'({gen_req, reward_valid, reward_protected, reward_slowly, grade_pulse}), 0);
        check_val("arst_cell", int'({reward_x, reward_y}), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        spawn("req_after_rst", RW_PROTECT, 6'd10, 6'd12);
        check_val("place_xy", int'({reward_x, reward_y}), int'({6'd10, 6'd12}));

        // Protect collect: effect visible one clk after the tick cycle
        head_x = 6'd10; head_y = 6'd12;
        tick_4hz = 1'b1;
        @(negedge clk);
        tick_4hz = 1'b0;
        head_x = '0; head_y = '0;
        check_val("collect_valid", int'(reward_valid), 0);
        check_val("collect_prot", int'(reward_protected), 1);
        check_val("collect_remain", int'(protect_remain), 30);
        step();
        pulse_tick();
        check_val("prot_remain_29", int'(protect_remain), 29);
        n = 1;
        sb_push("protect_len", 30);
        while (reward_protected && n < 60) begin
            pulse_tick();
            n++;
        end
        sb_pop(n);
        check_val("prot_remain_end", int'(protect_remain), 0);

        // Four candidates on the food cell
        check_val("req_pending", int'(gen_req), 1);
        n = 0;
        sb_push("reject_reqs", 4);
        while (gen_req && n < 8) begin
            give_ack(RW_SLOW, food_x, food_y);
            n++;
        end
        sb_pop(n);
        check_val("reject_valid", int'(reward_valid), 0);
        spawn("req_after_reject", RW_SLOW, 6'd20, 6'd20);
        check_val("slow_placed", int'(reward_valid), 1);

        // Uncollected lifetime
        n = 0;
        sb_push("lifetime", 40);
        while (reward_valid && n < 60) begin
            pulse_tick();
            n++;
        end
        sb_pop(n);

        // Hit on the 40th tick
        spawn("req_after_despawn", RW_SLOW, 6'd21, 6'd21);
        ticks(39);
        check_val("life_39_valid", int'(reward_valid), 1);
        hit_tick(6'd21, 6'd21);
        check_val("last_tick_valid", int'(reward_valid), 0);
        check_val("last_tick_slow", int'(reward_slowly), 1);
        check_val("last_tick_remain", int'(slow_remain), 30);

        // Reload and concurrency
        spawn("req_p1", RW_PROTECT, 6'd5, 6'd5);
        hit_tick(6'd5, 6'd5);
        check_val("p1_prot", int'(protect_remain), 30);
        check_val("p1_slow", int'(slow_remain), 9);
        spawn("req_p2", RW_PROTECT, 6'd6, 6'd6);
        ticks(5);
        check_val("p2_prot5", int'(protect_remain), 5);
        check_val("p2_slow_off", int'(reward_slowly), 0);
        hit_tick(6'd6, 6'd6);
        check_val("p2_reload", int'(protect_remain), 30);
        spawn("req_s", RW_SLOW, 6'd7, 6'd7);
        hit_tick(6'd7, 6'd7);
        check_val("both_active", int'({reward_protected, reward_slowly}), 3);
        check_val("both_prot", int'(protect_remain), 9);
        check_val("both_slow", int'(slow_remain), 30);

        // Leave RUNNING while a request is outstanding
        measure_req("req_pending2");
        game_status = 2'b01;
        step();
        check_val("stop_req", int'(gen_req), 0);
        check_val("stop_effects", int'({reward_protected, reward_slowly, reward_valid}), 0);
        check_val("stop_remain", int'(slow_remain), 0);

        // Grade collect
        game_status = RUNNING;
        step();
        spawn("req_grade", RW_GRADE, 6'd8, 6'd8);
        head_x = 6'd8; head_y = 6'd8;
        tick_4hz = 1'b1;
        @(negedge clk);
        tick_4hz = 1'b0;
        head_x = '0; head_y = '0;
        check_val("grade_pulse_hi", int'(grade_pulse), 1);
        @(negedge clk);
        check_val("grade_pulse_lo", int'(grade_pulse), 0);
        check_val("grade_no_effect", int'({reward_protected, reward_slowly, reward_valid}), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
